// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: access-size
// encodings, FSM state type, byte-enable patterns and small decode helpers.
package lsu_pkg;

    localparam int LANE_WIDTH = 32;

    // Access size/sign encodings carried on funct3.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns before shifting to the addressed lane.
    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    // Only the low two funct3 bits select the size; the unused encodings
    // (011/110/111) fall into the word case.
    function automatic lsu_size_t f3_size(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input lsu_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_m_load_extend.sv
// Selects the addressed byte/half from a read word and sign- or
// zero-extends it; words pass through unchanged.
module load_extend
    import lsu_pkg::*;
(
    input  logic [LANE_WIDTH-1:0] rdata_i,
    input  logic [1:0]            off_i,
    input  logic [2:0]            funct3_i,
    output logic [LANE_WIDTH-1:0] data_o
);

    logic [LANE_WIDTH-1:0] shifted;
    logic                  zero_ext;

    // Align the addressed lane to bit 0, then extend according to size/sign.
    always_comb begin
        shifted  = rdata_i >> {off_i, 3'b000};
        zero_ext = funct3_i[2];
        case (f3_size(funct3_i[1:0]))
            SZ_B:    data_o = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
            SZ_H:    data_o = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_m.sv
// Memory-stage load/store unit. Launches one request/grant/response access
// per aligned load or store, stalls the pipeline until it completes, and
// flags misaligned accesses instead of issuing them. Lane logic is 32-bit
// only; DATA_WIDTH must stay at 32.
module lsu_m
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int FUNCT3_WIDTH   = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      MemReadM,
    input  logic                      MemWriteM,
    input  logic [MEM_ADDR_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0]     WriteDataM,
    input  logic [FUNCT3_WIDTH-1:0]   funct3M,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]                mem_be,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      StallM,
    output logic [DATA_WIDTH-1:0]     ReadDataM,
    output logic                      MisalignM
);

    lsu_state_t state_q, state_d;

    logic                      access;
    logic [1:0]                off_in;
    lsu_size_t                 size_in;
    logic                      mis_in;
    logic [3:0]                be_in;
    logic [DATA_WIDTH-1:0]     wdata_in;
    logic                      start;
    logic                      load_done;

    logic                      we_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [3:0]                be_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [2:0]                f3_q;
    logic [1:0]                off_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [DATA_WIDTH-1:0]     load_ext;

    assign access  = MemReadM | MemWriteM;
    assign off_in  = ALUResultM[1:0];
    assign size_in = f3_size(funct3M[1:0]);
    assign mis_in  = is_misaligned(size_in, off_in);

    // Byte enables and lane-replicated store data for the incoming access.
    always_comb begin
        be_in    = BE_W;
        wdata_in = WriteDataM;
        case (size_in)
            SZ_B: begin
                be_in    = BE_B << off_in;
                wdata_in = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                be_in    = BE_H << off_in;
                wdata_in = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus the handshake/stall outputs. RESP is a deliberate
    // non-stalling cycle so the pipeline advances before the next access.
    always_comb begin
        state_d   = state_q;
        StallM    = 1'b0;
        MisalignM = 1'b0;
        mem_req   = 1'b0;
        start     = 1'b0;
        load_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (mis_in) begin
                        MisalignM = 1'b1;
                    end else begin
                        StallM  = 1'b1;
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
                if (mem_gnt) state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                StallM = 1'b1;
                if (mem_rvalid) begin
                    load_done = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Holding registers keep request fields stable for the whole REQ phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
        end else if (start) begin
            we_q    <= MemWriteM;
            addr_q  <= {ALUResultM[MEM_ADDR_WIDTH-1:2], 2'b00};
            be_q    <= be_in;
            wdata_q <= wdata_in;
            f3_q    <= funct3M[2:0];
            off_q   <= off_in;
        end
    end

    load_extend u_load_extend (
        .rdata_i  (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_ext)
    );

    // Load result register; only a completed load updates it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)            rdata_q <= '0;
        else if (load_done) rdata_q <= load_ext;
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign ReadDataM = rdata_q;

endmodule
